// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding I-cache request, {ins, pc} handoff to decode,
// and branch/jump redirect with wrong-path squash. Define IF_PERF_CNT_EN for fetch/squash counters.
module if_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          IF_TO_ID_BUS_WD = 64,
    parameter int          BJ_BUS_WD       = 34
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_allowin,
    input  logic [BJ_BUS_WD-1:0]       bj_bus,
    output logic                       if_to_id_valid,
    output logic [IF_TO_ID_BUS_WD-1:0] if_to_id_bus,
    output logic                       inst_req_valid,
    input  logic                       inst_req_ready,
    output logic [31:0]                inst_addr,
    input  logic                       inst_resp_valid,
    output logic                       inst_resp_ready,
    input  logic [31:0]                inst_rdata
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]                fetch_cnt,
    output logic [31:0]                squash_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t                       state;
    logic [31:0]                  fetch_pc;
    logic                         cancel;
    logic [IF_TO_ID_BUS_WD-1:0]   if_buf_p0;

    logic        redirect;
    logic [31:0] bj_target;

    assign redirect  = bj_bus[33] & bj_bus[32];
    assign bj_target = bj_bus[31:0] & ~32'd1;

    assign inst_req_valid  = (state == REQ);
    assign inst_resp_ready = (state == WAIT);
    assign inst_addr       = fetch_pc;
    // A redirect in HOLD withdraws the held instruction in the same cycle.
    assign if_to_id_valid  = (state == HOLD) && !redirect;
    assign if_to_id_bus    = if_buf_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            cancel    <= 1'b0;
            if_buf_p0 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect) fetch_pc <= bj_target;
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= bj_target;
                        if (inst_req_ready) begin
                            state  <= WAIT;
                            cancel <= 1'b1;
                        end
                    end else if (inst_req_ready) begin
                        state  <= WAIT;
                        cancel <= 1'b0;
                    end
                end
                WAIT: begin
                    if (inst_resp_valid) begin
                        if (cancel || redirect) begin
                            cancel <= 1'b0;
                            state  <= REQ;
                            if (redirect) fetch_pc <= bj_target;
                        end else begin
                            if_buf_p0 <= {inst_rdata, fetch_pc};
                            fetch_pc  <= fetch_pc + 32'd4;
                            state     <= HOLD;
                        end
                    end else if (redirect) begin
                        // Response still owed for the old address; mark it for discard.
                        cancel   <= 1'b1;
                        fetch_pc <= bj_target;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        fetch_pc <= bj_target;
                        state    <= REQ;
                    end else if (id_allowin) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt  <= 32'd0;
            squash_cnt <= 32'd0;
        end else begin
            if (if_to_id_valid && id_allowin) fetch_cnt <= fetch_cnt + 32'd1;
            if (((state == WAIT) && inst_resp_valid && (cancel || redirect)) ||
                ((state == HOLD) && redirect))
                squash_cnt <= squash_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a transaction-level fetch model and a small I-memory responder.
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_allowin = 1'b0;
    logic [33:0] bj_bus = '0;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic        inst_req_valid;
    logic        inst_req_ready = 1'b0;
    logic [31:0] inst_addr;
    logic        inst_resp_valid = 1'b0;
    logic        inst_resp_ready;
    logic [31:0] inst_rdata = '0;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_allowin     (id_allowin),
        .bj_bus         (bj_bus),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_bus   (if_to_id_bus),
        .inst_req_valid (inst_req_valid),
        .inst_req_ready (inst_req_ready),
        .inst_addr      (inst_addr),
        .inst_resp_valid(inst_resp_valid),
        .inst_resp_ready(inst_resp_ready),
        .inst_rdata     (inst_rdata)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .squash_cnt     (squash_cnt)
`endif
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1300_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: architectural next pc, outstanding request, held instruction, counters.
    logic [31:0] m_pc = RESET_PC;
    logic        m_out = 1'b0;
    logic        m_dirty = 1'b0;
    logic        m_held = 1'b0;
    logic [31:0] m_fetch = '0;
    logic [31:0] m_squash = '0;

    always @(negedge clk) begin
        logic        redir;
        logic [31:0] tgt;
        redir = bj_bus[33] & bj_bus[32];
        tgt   = bj_bus[31:0] & ~32'd1;
        if (!rst) begin
            chk("rst_valid", 64'(if_to_id_valid), 64'd0);
            chk("rst_bus", if_to_id_bus, 64'd0);
            chk("rst_req_valid", 64'(inst_req_valid), 64'd0);
            chk("rst_resp_ready", 64'(inst_resp_ready), 64'd0);
            chk("rst_addr", 64'(inst_addr), 64'(RESET_PC));
            m_pc = RESET_PC; m_out = 0; m_dirty = 0; m_held = 0; m_fetch = 0; m_squash = 0;
        end else begin
            chk("valid", 64'(if_to_id_valid), 64'(m_held && !redir));
            if (if_to_id_valid) chk("bus", if_to_id_bus, {memf(m_pc), m_pc});
`ifdef IF_PERF_CNT_EN
            chk("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
            chk("squash_cnt", 64'(squash_cnt), 64'(m_squash));
`endif
            if (inst_req_valid && inst_req_ready) begin
                chk("one_outstanding", 64'(m_out), 64'd0);
                if (!redir) chk("req_addr", 64'(inst_addr), 64'(m_pc));
                m_out = 1; m_dirty = redir;
            end else if (inst_resp_valid && inst_resp_ready) begin
                if (m_dirty || redir) m_squash = m_squash + 1;
                else m_held = 1;
                m_out = 0; m_dirty = 0;
            end else if (redir && m_out) begin
                m_dirty = 1;
            end
            if (if_to_id_valid && id_allowin) begin
                m_fetch = m_fetch + 1; m_pc = m_pc + 32'd4; m_held = 0;
            end
            if (redir) begin
                if (m_held) m_squash = m_squash + 1;
                m_held = 0; m_pc = tgt;
            end
        end
    end

    // Stimulus-side logs and memory responder state
    logic [31:0] hs_q[$];
    logic [63:0] xb_q[$];
    int          xc_q[$];
    int          cyc_n = 0;
    int          lat = 1;
    logic        pend = 1'b0;
    int          wcnt = 0;
    logic [31:0] paddr = '0;

    task automatic cyc();
        logic        hs, rsp;
        logic [31:0] a;
        hs  = inst_req_valid && inst_req_ready && rst;
        rsp = inst_resp_valid && inst_resp_ready;
        a   = inst_addr;
        if (if_to_id_valid && id_allowin) begin
            xb_q.push_back(if_to_id_bus);
            xc_q.push_back(cyc_n);
        end
        if (hs) hs_q.push_back(a);
        @(posedge clk); #1;
        cyc_n++;
        if (!rst) begin
            pend = 0; inst_resp_valid = 0;
            return;
        end
        if (rsp) begin inst_resp_valid = 0; pend = 0; end
        if (hs) begin pend = 1; wcnt = lat; paddr = a; end
        if (pend && !inst_resp_valid) begin
            if (wcnt <= 1) begin inst_resp_valid = 1; inst_rdata = memf(paddr); end
            else wcnt--;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, hn;
        #2 rst = 1'b0;
        repeat (3) cyc();
        chk("lit_rst_addr", 64'(inst_addr), 64'h0);
        chk("lit_rst_valid", 64'(if_to_id_valid), 64'd0);

        // Straight-line fetch, 1-cycle memory, decode always ready
        id_allowin = 1; inst_req_ready = 1; lat = 1; rst = 1;
        for (int i = 0; i < 30 && !(if_to_id_valid && if_to_id_bus[31:0] == 32'h8); i++) cyc();
        id_allowin = 0;
        chk("reach_hold_8", 64'(if_to_id_valid && if_to_id_bus[31:0] == 32'h8), 64'd1);
        chk("hs_count_3", 64'(hs_q.size()), 64'd3);
        if (hs_q.size() >= 3) begin
            chk("addr0", 64'(hs_q[0]), 64'h0);
            chk("addr1", 64'(hs_q[1]), 64'h4);
            chk("addr2", 64'(hs_q[2]), 64'h8);
        end
        chk("xfer_count_2", 64'(xb_q.size()), 64'd2);
        if (xb_q.size() >= 2) begin
            chk("xfer0", xb_q[0], 64'h13000000_00000000);
            chk("xfer1", xb_q[1], 64'h13000004_00000004);
            chk("xfer_spacing", 64'(xc_q[1] - xc_q[0]), 64'd3);
        end

        // Decode stalls in HOLD; a non-writing bj_bus entry must not redirect
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bj_bus = {1'b1, 1'b0, 32'h0000_0300};
            cyc();
            bj_bus = '0;
            chk("stall_valid", 64'(if_to_id_valid), 64'd1);
            chk("stall_bus", if_to_id_bus, 64'h13000008_00000008);
        end
        chk("stall_no_req", 64'(hs_q.size()), 64'd3);
        id_allowin = 1;
        cyc(); cyc();
        chk("after_stall_hs", 64'(hs_q.size()), 64'd4);
        if (hs_q.size() >= 4) chk("addr_c", 64'(hs_q[3]), 64'hC);

        // Redirect while waiting for pc 0x10, response arrives two cycles later
        for (int i = 0; i < 30 && !(inst_req_valid && inst_addr == 32'h10); i++) cyc();
        chk("reach_req_10", 64'(inst_req_valid && inst_addr == 32'h10), 64'd1);
        lat = 3;
        cyc();
        chk("wait_10", 64'(inst_resp_ready), 64'd1);
        n = xb_q.size(); hn = hs_q.size();
        bj_bus = {1'b1, 1'b1, 32'h0000_0100};
        cyc();
        bj_bus = '0; lat = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("wait_redir_novalid", 64'(if_to_id_valid), 64'd0);
        end
        for (int i = 0; i < 10 && hs_q.size() == hn; i++) cyc();
        chk("wait_redir_addr", 64'(hs_q[$]), 64'h100);
        chk("wait_redir_noxfer", 64'(xb_q.size()), 64'(n));

        // Redirect in HOLD with decode ready in the same cycle (target bit 0 set)
        for (int i = 0; i < 20 && !if_to_id_valid; i++) cyc();
        bj_bus = {1'b1, 1'b1, 32'h0000_0201};
        #1;
        chk("hold_redir_valid", 64'(if_to_id_valid), 64'd0);
        n = xb_q.size(); hn = hs_q.size();
        cyc();
        bj_bus = '0;
        chk("hold_redir_noxfer", 64'(xb_q.size()), 64'(n));
        for (int i = 0; i < 10 && hs_q.size() == hn; i++) cyc();
        chk("hold_redir_addr", 64'(hs_q[$]), 64'h200);

        // Redirect in REQ while memory is not ready
        inst_req_ready = 0;
        for (int i = 0; i < 20 && !inst_req_valid; i++) cyc();
        chk("req_204", 64'(inst_addr), 64'h204);
        chk("xfer_200", xb_q[$], 64'h13000200_00000200);
        hn = hs_q.size();
        bj_bus = {1'b1, 1'b1, 32'h0000_0040};
        cyc();
        bj_bus = '0;
        chk("req_redir_valid", 64'(inst_req_valid), 64'd1);
        chk("req_redir_addr", 64'(inst_addr), 64'h40);
        cyc();
        chk("req_notready_nohs", 64'(hs_q.size()), 64'(hn));
        inst_req_ready = 1;
        cyc();
        chk("req_accepted_40", 64'(hs_q[$]), 64'h40);

        // Redirect in REQ on the handshake cycle
        for (int i = 0; i < 20 && !(inst_req_valid && inst_addr == 32'h44); i++) cyc();
        chk("reach_req_44", 64'(inst_req_valid && inst_addr == 32'h44), 64'd1);
        bj_bus = {1'b1, 1'b1, 32'h0000_0040};
        cyc();
        bj_bus = '0;
        n = xb_q.size();
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("hs_redir_novalid", 64'(if_to_id_valid), 64'd0);
        end
        chk("hs_redir_prev", 64'(hs_q[hs_q.size() - 2]), 64'h44);
        chk("hs_redir_next", 64'(hs_q[$]), 64'h40);
        chk("hs_redir_noxfer", 64'(xb_q.size()), 64'(n));
        for (int i = 0; i < 10 && !if_to_id_valid; i++) cyc();
        chk("refetch_40", if_to_id_bus, 64'h13000040_00000040);

        // Asynchronous reset in the middle of WAIT
        lat = 3;
        for (int i = 0; i < 20 && !inst_resp_ready; i++) cyc();
        cyc();
        chk("mid_wait", 64'(inst_resp_ready), 64'd1);
        rst = 0;
        #1;
        chk("async_valid", 64'(if_to_id_valid), 64'd0);
        chk("async_bus", if_to_id_bus, 64'd0);
        chk("async_req", 64'(inst_req_valid), 64'd0);
        chk("async_resp_ready", 64'(inst_resp_ready), 64'd0);
        chk("async_addr", 64'(inst_addr), 64'(RESET_PC));
`ifdef IF_PERF_CNT_EN
        chk("async_fetch_cnt", 64'(fetch_cnt), 64'd0);
        chk("async_squash_cnt", 64'(squash_cnt), 64'd0);
`endif
        repeat (2) cyc();
        lat = 1; rst = 1;
        hn = hs_q.size();
        for (int i = 0; i < 10 && hs_q.size() == hn; i++) cyc();
        chk("post_reset_addr", 64'(hs_q[$]), 64'(RESET_PC));
        repeat (6) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
